// File: rtl/add_64x1.sv
// rtl/add_64x1.sv - 64-bit ripple-carry adder with signed overflow and one output register stage
module add_64x1 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] sum,
    output logic        overflow,
    output logic        out_valid
);

    logic [63:0] core_sum;
    logic        core_ovf;
    logic        carry;
    logic        carry_in_msb;

    // Bit-serial ripple chain, LSB first; the carry entering bit 63 is kept for overflow.
    always_comb begin
        carry        = 1'b0;
        carry_in_msb = 1'b0;
        core_sum     = '0;
        for (int i = 0; i < 64; i++) begin
            if (i == 63) begin
                carry_in_msb = carry;
            end
            core_sum[i] = a[i] ^ b[i] ^ carry;
            carry       = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        core_ovf = carry_in_msb ^ carry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum       <= '0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum      <= core_sum;
                overflow <= core_ovf;
            end
        end
    end

endmodule

// File: tb/tb_add_64x1.sv
// tb/tb_add_64x1.sv - randomized self-checking bench for add_64x1 against an arithmetic model
module tb_add_64x1;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] sum;
    logic        overflow;
    logic        out_valid;

    int n_checks;
    int n_errors;

    logic [63:0] m_sum;
    logic        m_ovf;
    logic        m_valid;

    add_64x1 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .sum      (sum),
        .overflow (overflow),
        .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
        end
    endtask

    // Reference: exact signed sum in 65 bits; overflow when it does not fit in 64.
    task automatic model(input logic [63:0] x, input logic [63:0] y);
        logic signed [64:0] wide;
        wide  = $signed({x[63], x}) + $signed({y[63], y});
        m_sum = wide[63:0];
        m_ovf = (wide > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (wide < -65'sh0_8000_0000_0000_0000);
    endtask

    task automatic step(input logic v, input logic [63:0] x, input logic [63:0] y, input string tag);
        in_valid = v;
        a        = x;
        b        = y;
        @(posedge clk);
        #1;
        if (v) model(x, y);
        m_valid = v;
        check({tag, ".valid"}, {63'd0, out_valid}, {63'd0, m_valid});
        check({tag, ".sum"}, sum, m_sum);
        check({tag, ".ovf"}, {63'd0, overflow}, {63'd0, m_ovf});
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".sum"}, sum, 64'd0);
        check({tag, ".ovf"}, {63'd0, overflow}, 64'd0);
        check({tag, ".valid"}, {63'd0, out_valid}, 64'd0);
    endtask

    function automatic logic [63:0] pick();
        logic [63:0] edges [8];
        edges = '{64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
                  64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001,
                  64'h7FFF_FFFF_FFFF_FFFE, 64'h4000_0000_0000_0000};
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 7)];
        return {$urandom, $urandom};
    endfunction

    logic [63:0] da [14];
    logic [63:0] db [14];

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_sum    = '0;
        m_ovf    = 1'b0;
        m_valid  = 1'b0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        #1;
        check_zero("reset");
        repeat (2) @(posedge clk);
        #4 rst_n = 1'b1;

        da = '{64'd1157483647, 64'h529F_4B7F_7D4B_068D, 64'd23, 64'd9, 64'd9,
               -64'sd2, -64'sd2, 64'd2, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF,
               64'h8000_0000_0000_0000, -64'sd1, 64'd5, 64'd6};
        db = '{64'd1, 64'h529F_4B7F_7D4B_068D, 64'd0, 64'd9, -64'sd9,
               64'd17, -64'sd17, -64'sd17, 64'd0, 64'd1,
               64'h8000_0000_0000_0000, 64'd1, 64'd7, 64'd8};

        // Directed vectors issued back-to-back with no bubbles.
        for (int i = 0; i < 14; i++) step(1'b1, da[i], db[i], $sformatf("dir%0d", i));

        // Spot-check a few plan values directly, independent of the model.
        step(1'b1, 64'd1157483647, 64'd1, "plan_first");
        check("plan_first.abs", sum, 64'd1157483648);
        step(1'b1, 64'h529F_4B7F_7D4B_068D, 64'h529F_4B7F_7D4B_068D, "plan_ovf");
        check("plan_ovf.abs", sum, 64'hA53E_96FE_FA96_0D1A);
        check("plan_ovf.flag", {63'd0, overflow}, 64'd1);
        step(1'b1, -64'sd2, -64'sd17, "plan_neg");
        check("plan_neg.abs", sum, -64'sd19);

        // Hold: idle cycles with changing operands must not disturb the result.
        step(1'b0, 64'h1234, 64'h5678, "hold0");
        step(1'b0, 64'hFFFF_0000, 64'h1, "hold1");
        check("hold.abs", sum, -64'sd19);

        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 3) != 0, pick(), pick(), $sformatf("rnd%0d", i));

        // Asynchronous reset between edges after a capture.
        step(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, "pre_rst");
        #2 rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        in_valid = 1'b1;
        a        = 64'd100;
        b        = 64'd200;
        @(posedge clk);
        #1;
        check_zero("rst_held");
        #2 rst_n = 1'b1;
        m_sum = '0;
        m_ovf = 1'b0;
        step(1'b0, 64'd3, 64'd4, "post_rst_idle");
        step(1'b1, 64'd3, 64'd4, "post_rst_cap");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
